async_fifo: RTL and testbench

Parameterised single-clock FIFO buffer, W bits wide and D entries deep, with full and empty flags. It decouples a producer and a consumer that run on the same clock but issue write and read requests independently. Storage is a register array addressed by wrap-aware read and write pointers. Read data is registered.

---
 rtl/async_fifo_pkg.sv | 17 +
 rtl/async_fifo_mem.sv | 40 ++++
 rtl/async_fifo.sv | 66 ++++++
 tb/tb_async_fifo.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants and address-width helper for async_fifo
package async_fifo_pkg;

   localparam int W_DEF = 8;
   localparam int D_DEF = 32;

   // Smallest aw with 2**aw >= depth; exact log2 for the power-of-two depths used here.
   function automatic int addr_width(input int depth);
      int aw;
      aw = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) aw = i + 1;
      end
      return aw;
   endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// rtl/async_fifo_mem.sv - DxW register array, one synchronous write port, one registered read port
// Array contents are never reset; only the read register clears.
module async_fifo_mem
   import async_fifo_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int D  = D_DEF,
   parameter int AW = addr_width(D)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [D];
   logic [W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Holds the last popped word until the next accepted read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock FIFO with wrap-bit pointers, full/empty flags, registered read data
// Optional occupancy output `level` when ASYNC_FIFO_LEVEL_EN is defined.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int D = D_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic                     r_en,
   input  logic [W-1:0]             d_in,
   output logic [W-1:0]             d_out,
   output logic                     full,
   output logic                     empty
`ifdef ASYNC_FIFO_LEVEL_EN
   ,
   output logic [addr_width(D):0]   level
`endif
);

   localparam int AW = addr_width(D);

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_wr_acc;
   logic        w_rd_acc;

   // Same low bits with differing wrap bits means the writer is one lap ahead.
   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

   assign w_wr_acc = w_en && !full  && !rst;
   assign w_rd_acc = r_en && !empty && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_rd_acc) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   async_fifo_mem #(
      .W  (W),
      .D  (D),
      .AW (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr[AW-1:0]),
      .i_wdata (d_in),
      .i_re    (w_rd_acc),
      .i_raddr (r_rptr[AW-1:0]),
      .o_rdata (d_out)
   );

`ifdef ASYNC_FIFO_LEVEL_EN
   assign level = r_wptr - r_rptr;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - self-checking scoreboard bench for async_fifo (W=8, D=32)
module tb_async_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       w_en = 1'b0;
   logic       r_en = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [7:0] d_out;
   logic       full;
   logic       empty;
`ifdef ASYNC_FIFO_LEVEL_EN
   logic [5:0] level;
`endif

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];
   logic [7:0] m_dout = 8'h00;

   always #5 clk = ~clk;

   async_fifo dut (
      .clk   (clk),
      .rst   (rst),
      .w_en  (w_en),
      .r_en  (r_en),
      .d_in  (d_in),
      .d_out (d_out),
      .full  (full),
      .empty (empty)
`ifdef ASYNC_FIFO_LEVEL_EN
      ,
      .level (level)
`endif
   );

   // Drives one cycle and advances the scoreboard using pre-edge occupancy.
   task automatic drive(input logic we, input logic re, input logic [7:0] din);
      bit do_wr;
      bit do_rd;
      w_en = we;
      r_en = re;
      d_in = din;
      do_wr = we && (sb.size() < 32);
      do_rd = re && (sb.size() != 0);
      if (rst) begin
         sb.delete();
         m_dout = 8'h00;
      end else begin
         if (do_rd) m_dout = sb.pop_front();
         if (do_wr) sb.push_back(din);
      end
      @(posedge clk);
      #1;
      w_en = 1'b0;
      r_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
      checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", d_out); end
   endtask

   task automatic test_partial();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         if (i == 0) begin
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL partial_first_write_empty: got %b expected 0", empty); end
         end
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         checks++; if (d_out !== m_dout) begin errors++; $display("FAIL partial_read1 #%0d: got %h expected %h", i, d_out, m_dout); end
      end
      checks++; if (d_out !== 8'd9) begin errors++; $display("FAIL partial_read1_last: got %h expected 09", d_out); end
      for (int i = 20; i < 35; i++) drive(1'b1, 1'b0, 8'(i));
      for (int i = 0; i < 25; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         checks++; if (d_out !== m_dout) begin errors++; $display("FAIL partial_read2 #%0d: got %h expected %h", i, d_out, m_dout); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL partial_drained_empty: got %b expected 1", empty); end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         checks++; if (d_out !== 8'd34) begin errors++; $display("FAIL partial_extra_read: got %h expected 22", d_out); end
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 32; i++) begin
         checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early #%0d: got %b expected 0", i, full); end
         drive(1'b1, 1'b0, 8'(i));
      end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b expected 1", full); end
      drive(1'b1, 1'b0, 8'hAA);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after_drop: got %b expected 1", full); end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         checks++; if (d_out !== m_dout) begin errors++; $display("FAIL full_drain #%0d: got %h expected %h", i, d_out, m_dout); end
         if (i == 0) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b expected 0", full); end
         end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty: got %b expected 1", empty); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(100 + i));
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 8'(200 + i));
         checks++; if (d_out !== m_dout) begin errors++; $display("FAIL simul_dout #%0d: got %h expected %h", i, d_out, m_dout); end
         checks++; if ({empty, full} !== 2'b00) begin errors++; $display("FAIL simul_flags #%0d: got %b expected 00", i, {empty, full}); end
`ifdef ASYNC_FIFO_LEVEL_EN
         checks++; if (level !== 6'd5) begin errors++; $display("FAIL simul_level #%0d: got %0d expected 5", i, level); end
`endif
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         checks++; if (d_out !== m_dout) begin errors++; $display("FAIL simul_drain #%0d: got %h expected %h", i, d_out, m_dout); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b expected 1", empty); end
      for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 8'(i + 64));
      drive(1'b1, 1'b1, 8'h55);
      checks++; if (d_out !== 8'd64) begin errors++; $display("FAIL simul_full_read: got %h expected 40", d_out); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full_drop: got %b expected 0", full); end
      for (int i = 0; i < 31; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         checks++; if (d_out !== m_dout) begin errors++; $display("FAIL simul_full_drain #%0d: got %h expected %h", i, d_out, m_dout); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_full_empty: got %b expected 1", empty); end
   endtask

   task automatic test_wrap();
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 8'(p * 40 + i + 1));
         checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full pass %0d: got %b expected 1", p, full); end
         for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++; if (d_out !== m_dout) begin errors++; $display("FAIL wrap_dout pass %0d #%0d: got %h expected %h", p, i, d_out, m_dout); end
         end
         checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty pass %0d: got %b expected 1", p, empty); end
      end
      drive(1'b0, 1'b1, 8'h00);
      checks++; if (d_out !== 8'd112) begin errors++; $display("FAIL underflow_dout: got %h expected 70", d_out); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL underflow_empty: got %b expected 1", empty); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'(i + 150));
      rst = 1'b1;
      drive(1'b1, 1'b1, 8'hEE);
      rst = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b expected 0", full); end
      checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h expected 00", d_out); end
      drive(1'b1, 1'b0, 8'h5A);
      drive(1'b0, 1'b1, 8'h00);
      checks++; if (d_out !== 8'h5A) begin errors++; $display("FAIL midrst_newword: got %h expected 5a", d_out); end
      checks++; if (d_out !== m_dout) begin errors++; $display("FAIL midrst_model: got %h expected %h", d_out, m_dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_final_empty: got %b expected 1", empty); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_partial();
      test_full();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
